// File: rtl/uart_command_sequencer_pkg.sv
// uart_command_sequencer_pkg
//   Shared definitions for the UART command sequencer: opcode values carried
//   in control[7:5], status-byte bit positions, the sequencer state encoding
//   and a helper that assembles the status byte.
package uart_command_sequencer_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_EXEC  = 3'd3;

  localparam int ST_ERR = 7;
  localparam int ST_TMO = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACK       = 3'd1,
    DECODE    = 3'd2,
    EXEC_WAIT = 3'd3,
    SEND      = 3'd4,
    DRAIN     = 3'd5
  } seqState_t;

  // Status byte layout: {error, timeout, opcode echo, address echo}.
  function automatic logic [7:0] buildStatus(input logic err, input logic tmo,
                                             input logic [2:0] op, input logic [2:0] addr);
    logic [7:0] s;
    s         = 8'h00;
    s[ST_ERR] = err;
    s[ST_TMO] = tmo;
    s[5:3]    = op;
    s[2:0]    = addr;
    return s;
  endfunction

endpackage

// File: rtl/uart_command_sequencer_regfile.sv
// seq_register_file
//   NUM_REGS host-visible registers of WIDTH*8 bits each.
//   Ports:
//     masterClock  - clock, rising edge
//     reset        - asynchronous active-high reset, clears every register
//     writeEnable  - write strobe; writeAddr/writeData sampled on the clock
//     readAddr     - combinational read address; out-of-range reads give 0
//     readData     - contents of register readAddr
//     regFile      - all registers flattened, register 0 in the LSBs
module seq_register_file #(
  parameter int WIDTH    = 4,
  parameter int NUM_REGS = 8
) (
  input  logic                        masterClock,
  input  logic                        reset,
  input  logic                        writeEnable,
  input  logic [2:0]                  writeAddr,
  input  logic [WIDTH*8-1:0]          writeData,
  input  logic [2:0]                  readAddr,
  output logic [WIDTH*8-1:0]          readData,
  output logic [NUM_REGS*WIDTH*8-1:0] regFile
);

  localparam int DW = WIDTH * 8;

  logic [DW-1:0] regs [NUM_REGS];

  // Register storage with a single synchronous write port.
  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEnable) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (writeAddr == 3'(i)) begin
          regs[i] <= writeData;
        end
      end
    end
  end

  // Read mux built as an AND-OR so an address past NUM_REGS reads as zero.
  always_comb begin
    readData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      readData = readData | ({DW{readAddr == 3'(i)}} & regs[i]);
    end
  end

  // Flattened view of every register for the host-side debug bus.
  always_comb begin
    regFile = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regFile[i*DW +: DW] = regs[i];
    end
  end

endmodule

// File: rtl/uart_command_sequencer.sv
// uart_command_sequencer
//   Takes one packet (control byte + WIDTH data bytes) from the UART I/O
//   block, acknowledges it, performs a register WRITE/READ or a DUT EXEC,
//   and hands a status byte plus WIDTH-byte response back for transmission.
//   Ports:
//     masterClock, reset             - clock / async active-high reset
//     dataReceived, control,
//     inputData, clearDR             - packet in and its acknowledge
//     transmitting, transmit,
//     respStatus, respData           - response out and its handshake
//     dutStart, dutOperand,
//     dutDone, dutResult             - execute interface to the DUT
//     regFile                        - flattened host registers
//     busy                           - high whenever a command is in flight
module uart_command_sequencer
  import uart_command_sequencer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NUM_REGS = 8,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                        masterClock,
  input  logic                        reset,
  input  logic                        dataReceived,
  input  logic [7:0]                  control,
  input  logic [WIDTH*8-1:0]          inputData,
  output logic                        clearDR,
  input  logic                        transmitting,
  output logic                        transmit,
  output logic [7:0]                  respStatus,
  output logic [WIDTH*8-1:0]          respData,
  output logic                        dutStart,
  output logic [WIDTH*8-1:0]          dutOperand,
  input  logic                        dutDone,
  input  logic [WIDTH*8-1:0]          dutResult,
  output logic [NUM_REGS*WIDTH*8-1:0] regFile,
  output logic                        busy
);

  localparam int            DW         = WIDTH * 8;
  localparam int            CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0]    REG_COUNT  = 4'(NUM_REGS);

  seqState_t     state;
  logic [2:0]    opcodeReg;
  logic [2:0]    addrReg;
  logic [DW-1:0] dataReg;
  logic [CW-1:0] timer;

  logic          isWrite;
  logic          isRead;
  logic          isExec;
  logic          isError;
  logic          addrInRange;
  logic          writeEnable;
  logic [DW-1:0] readData;

  seq_register_file #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) registerFile (
    .masterClock (masterClock),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeAddr   (addrReg),
    .writeData   (dataReg),
    .readAddr    (addrReg),
    .readData    (readData),
    .regFile     (regFile)
  );

  // Decode of the latched control byte; reserved bits [4:3] are never stored.
  always_comb begin
    isWrite     = 1'b0;
    isRead      = 1'b0;
    isExec      = 1'b0;
    isError     = 1'b0;
    addrInRange = ({1'b0, addrReg} < REG_COUNT);
    case (opcodeReg)
      OP_NOP: begin
        isError = 1'b0;
      end
      OP_WRITE: begin
        isWrite = 1'b1;
        isError = !addrInRange;
      end
      OP_READ: begin
        isRead  = 1'b1;
        isError = !addrInRange;
      end
      OP_EXEC: begin
        isExec = 1'b1;
      end
      default: begin
        isError = 1'b1;
      end
    endcase
    if ((state == DECODE) && isWrite && !isError) begin
      writeEnable = 1'b1;
    end else begin
      writeEnable = 1'b0;
    end
  end

  // Command sequencer: packet handshake, decode, DUT execute, response handshake.
  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opcodeReg  <= 3'd0;
      addrReg    <= 3'd0;
      dataReg    <= '0;
      timer      <= '0;
      clearDR    <= 1'b0;
      transmit   <= 1'b0;
      respStatus <= 8'h00;
      respData   <= '0;
      dutStart   <= 1'b0;
      dutOperand <= '0;
      busy       <= 1'b0;
    end else begin
      // dutStart is a single-cycle pulse unless DECODE sets it again.
      dutStart <= 1'b0;
      case (state)
        IDLE: begin
          if (dataReceived) begin
            opcodeReg <= control[7:5];
            addrReg   <= control[2:0];
            dataReg   <= inputData;
            clearDR   <= 1'b1;
            busy      <= 1'b1;
            state     <= ACK;
          end
        end
        ACK: begin
          if (!dataReceived) begin
            clearDR <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          respStatus <= buildStatus(isError, 1'b0, opcodeReg, addrReg);
          if (isError) begin
            respData <= '0;
          end else if (isWrite) begin
            respData <= dataReg;
          end else if (isRead) begin
            respData <= readData;
          end else begin
            respData <= '0;
          end
          if (isExec) begin
            dutOperand <= dataReg;
            dutStart   <= 1'b1;
            timer      <= '0;
            state      <= EXEC_WAIT;
          end else begin
            state <= SEND;
          end
        end
        EXEC_WAIT: begin
          // dutDone seen while dutStart is still high belongs to the start
          // cycle itself and is not a completion.
          if (dutDone && !dutStart) begin
            respData <= dutResult;
            state    <= SEND;
          end else if (timer == TIMER_LAST) begin
            respStatus[ST_TMO] <= 1'b1;
            respData           <= '0;
            state              <= SEND;
          end else begin
            timer <= timer + CW'(1);
          end
        end
        SEND: begin
          if (!transmit) begin
            transmit <= 1'b1;
          end else if (transmitting) begin
            transmit <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!transmitting) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          clearDR  <= 1'b0;
          transmit <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_command_sequencer.sv
module tb_uart_command_sequencer;

  localparam int WIDTH    = 4;
  localparam int NUM_REGS = 4;
  localparam int TIMEOUT  = 16;

  logic         masterClock;
  logic         reset;
  logic         dataReceived;
  logic [7:0]   control;
  logic [31:0]  inputData;
  logic         clearDR;
  logic         transmitting;
  logic         transmit;
  logic [7:0]   respStatus;
  logic [31:0]  respData;
  logic         dutStart;
  logic [31:0]  dutOperand;
  logic         dutDone;
  logic [31:0]  dutResult;
  logic [127:0] regFile;
  logic         busy;

  uart_command_sequencer #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .masterClock  (masterClock),
    .reset        (reset),
    .dataReceived (dataReceived),
    .control      (control),
    .inputData    (inputData),
    .clearDR      (clearDR),
    .transmitting (transmitting),
    .transmit     (transmit),
    .respStatus   (respStatus),
    .respData     (respData),
    .dutStart     (dutStart),
    .dutOperand   (dutOperand),
    .dutDone      (dutDone),
    .dutResult    (dutResult),
    .regFile      (regFile),
    .busy         (busy)
  );

  int checksTotal  = 0;
  int checksPassed = 0;

  // Reference model state
  logic [31:0] modelRegs [NUM_REGS];
  logic [7:0]  expStatus;
  logic [31:0] expData;
  logic [31:0] expOperand;
  int          dutDelay;
  logic [31:0] dutResultVal;
  int          dutStartCount = 0;
  bit          execActive = 0;
  bit          tmoTimed = 0;
  int          sinceStart = 0;

  initial begin
    masterClock = 1'b0;
    forever #5 masterClock = ~masterClock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [127:0] flatModel();
    return {modelRegs[3], modelRegs[2], modelRegs[1], modelRegs[0]};
  endfunction

  // Response the host must see, derived from the packet and the DUT behaviour.
  // A DUT answering k cycles after it sees dutStart lands on cycle k+1 after
  // dutStart; anything later than TIMEOUT cycles is a timeout.
  task automatic predict(input logic [7:0] ctrl, input logic [31:0] data, input int k,
                         input logic [31:0] res, output logic [7:0] st,
                         output logic [31:0] d, output bit doWrite);
    int  op;
    int  a;
    bit  err;
    bit  tmo;
    op      = int'(ctrl[7:5]);
    a       = int'(ctrl[2:0]);
    err     = (op > 3) || (((op == 1) || (op == 2)) && (a >= NUM_REGS));
    tmo     = 1'b0;
    d       = 32'h0;
    doWrite = 1'b0;
    if (!err) begin
      if (op == 1) begin
        d       = data;
        doWrite = 1'b1;
      end else if (op == 2) begin
        d = modelRegs[a];
      end else if (op == 3) begin
        if ((k >= 0) && (k + 1 <= TIMEOUT)) d = res;
        else tmo = 1'b1;
      end
    end
    st = {err, tmo, ctrl[7:5], ctrl[2:0]};
  endtask

  // DUT stand-in: answers dutDelay cycles after seeing dutStart, or never if negative.
  initial begin
    dutDone   = 1'b0;
    dutResult = 32'h0;
    forever begin
      @(negedge masterClock);
      if (dutStart && !reset && (dutDelay >= 0)) begin
        repeat (dutDelay) @(posedge masterClock);
        #1;
        dutDone   = 1'b1;
        dutResult = dutResultVal;
        @(posedge masterClock);
        #1;
        dutDone   = 1'b0;
        dutResult = 32'h0;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge masterClock);
      if (reset) begin
        execActive = 1'b0;
      end else begin
        if (transmit) begin
          check("respStatus", respStatus, expStatus);
          check("respData", respData, expData);
        end
        if (!busy) check("regFile", regFile, flatModel());
        if (dutStart) begin
          dutStartCount++;
          execActive = 1'b1;
          tmoTimed   = 1'b0;
          sinceStart = 0;
        end else if (execActive) begin
          sinceStart++;
        end
        if (execActive) check("dutOperand", dutOperand, expOperand);
        if (execActive && respStatus[6] && !tmoTimed) begin
          check("timeoutLatency", sinceStart, TIMEOUT);
          tmoTimed = 1'b1;
        end
        if (transmit) execActive = 1'b0;
      end
    end
  end

  // Present a packet and release it once acknowledged; ackHold extra cycles of dataReceived.
  task automatic presentPacket(input logic [7:0] ctrl, input logic [31:0] data, input int ackHold);
    int n;
    @(posedge masterClock); #1;
    control      = ctrl;
    inputData    = data;
    dataReceived = 1'b1;
    n = 0;
    while (!clearDR && n < 20) begin
      @(posedge masterClock); #1;
      n++;
    end
    check("clearDR rise", clearDR, 1'b1);
    repeat (ackHold) begin
      @(posedge masterClock); #1;
      check("clearDR hold", clearDR, 1'b1);
    end
    dataReceived = 1'b0;
  endtask

  task automatic sendPacket(input logic [7:0] ctrl, input logic [31:0] data, input int ackHold,
                            input int txDelay, input int k, input logic [31:0] res);
    logic [7:0]  st;
    logic [31:0] d;
    bit          wr;
    int          startsBefore;
    int          n;
    predict(ctrl, data, k, res, st, d, wr);
    expStatus    = st;
    expData      = d;
    expOperand   = data;
    dutDelay     = k;
    dutResultVal = res;
    startsBefore = dutStartCount;
    presentPacket(ctrl, data, ackHold);
    if (ctrl[7:5] != 3'd3) begin
      // edge 1 leaves ACK, edge 2 registers the response, edge 3 raises transmit
      @(posedge masterClock); #1;
      check("clearDR drop", clearDR, 1'b0);
      check("latency edge1", transmit, 1'b0);
      @(posedge masterClock); #1;
      check("latency edge2", transmit, 1'b0);
      @(posedge masterClock); #1;
      check("latency edge3", transmit, 1'b1);
    end else begin
      n = 0;
      while (!transmit && n < 100) begin
        @(posedge masterClock); #1;
        n++;
      end
      check("transmit seen", transmit, 1'b1);
    end
    repeat (txDelay) begin
      @(posedge masterClock); #1;
      check("transmit held", transmit, 1'b1);
    end
    transmitting = 1'b1;
    @(posedge masterClock); #1;
    check("transmit drop", transmit, 1'b0);
    check("busy in drain", busy, 1'b1);
    @(posedge masterClock); #1;
    check("busy while transmitting", busy, 1'b1);
    transmitting = 1'b0;
    @(posedge masterClock); #1;
    check("busy release", busy, 1'b0);
    check("dutStart pulses", dutStartCount - startsBefore, (ctrl[7:5] == 3'd3) ? 1 : 0);
    if (wr) modelRegs[int'(ctrl[2:0])] = data;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " clearDR"}, clearDR, 1'b0);
    check({tag, " transmit"}, transmit, 1'b0);
    check({tag, " respStatus"}, respStatus, 8'h00);
    check({tag, " respData"}, respData, 32'h0);
    check({tag, " dutStart"}, dutStart, 1'b0);
    check({tag, " dutOperand"}, dutOperand, 32'h0);
    check({tag, " regFile"}, regFile, 128'h0);
    check({tag, " busy"}, busy, 1'b0);
  endtask

  task automatic applyReset(input string tag);
    @(posedge masterClock); #3;
    reset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = 32'h0;
    #1;
    checkAllZero(tag);
    @(posedge masterClock); #1;
    reset = 1'b0;
    repeat (20) begin
      @(posedge masterClock); #1;
      check({tag, " quiet transmit"}, transmit, 1'b0);
      check({tag, " quiet dutStart"}, dutStart, 1'b0);
    end
  endtask

  initial begin
    logic [7:0]  st;
    logic [31:0] d;
    bit          wr;
    int          n;
    reset        = 1'b1;
    dataReceived = 1'b0;
    control      = 8'h00;
    inputData    = 32'h0;
    transmitting = 1'b0;
    dutDelay     = -1;
    dutResultVal = 32'h0;
    expStatus    = 8'h00;
    expData      = 32'h0;
    expOperand   = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = 32'h0;
    repeat (3) @(posedge masterClock);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // WRITE then READ of register 2
    sendPacket(8'h22, 32'hDEADBEEF, 0, 0, -1, 32'h0);
    check("write status", respStatus, 8'h0A);
    check("write echo", respData, 32'hDEADBEEF);
    sendPacket(8'h42, 32'h0, 0, 0, -1, 32'h0);
    check("read status", respStatus, 8'h12);
    check("read data", respData, 32'hDEADBEEF);
    check("reg2 value", regFile, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});

    // Illegal address, illegal opcode, NOP, out-of-range READ
    sendPacket(8'h25, 32'h11111111, 0, 0, -1, 32'h0);
    check("bad addr status", respStatus, 8'h8D);
    check("bad addr data", respData, 32'h0);
    check("bad addr regs", regFile, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    sendPacket(8'hE0, 32'h22222222, 0, 0, -1, 32'h0);
    check("bad op status", respStatus, 8'hB8);
    sendPacket(8'h07, 32'h00000005, 0, 0, -1, 32'h0);
    check("nop status", respStatus, 8'h07);
    check("nop data", respData, 32'h0);
    sendPacket(8'h45, 32'h0, 0, 0, -1, 32'h0);
    check("bad read status", respStatus, 8'h95);

    // EXEC: normal, never-answering, last-cycle answer, one cycle late
    sendPacket(8'h60, 32'h00000005, 0, 0, 10, 32'h0000000A);
    check("exec status", respStatus, 8'h18);
    check("exec data", respData, 32'h0000000A);
    sendPacket(8'h60, 32'h00000009, 0, 0, -1, 32'h0);
    check("timeout status", respStatus, 8'h58);
    check("timeout data", respData, 32'h0);
    sendPacket(8'h60, 32'h00000003, 0, 0, 15, 32'h00001234);
    check("last cycle status", respStatus, 8'h18);
    check("last cycle data", respData, 32'h00001234);
    sendPacket(8'h60, 32'h00000004, 0, 0, 16, 32'h00005678);
    check("late status", respStatus, 8'h58);

    // Slow handshake on both sides, reserved bits set
    sendPacket(8'h2B, 32'h0BADF00D, 3, 5, -1, 32'h0);
    check("handshake status", respStatus, 8'h0B);
    repeat (4) begin
      @(posedge masterClock); #1;
      check("no second command", busy, 1'b0);
    end

    // Reset while waiting on the DUT
    predict(8'h60, 32'h00000077, -1, 32'h0, st, d, wr);
    expStatus  = st;
    expData    = d;
    expOperand = 32'h00000077;
    dutDelay   = -1;
    presentPacket(8'h60, 32'h00000077, 0);
    repeat (5) @(posedge masterClock);
    applyReset("exec reset");

    // Reset while holding transmit
    sendPacket(8'h22, 32'hDEADBEEF, 0, 0, -1, 32'h0);
    predict(8'h21, 32'h12345678, -1, 32'h0, st, d, wr);
    expStatus = st;
    expData   = d;
    presentPacket(8'h21, 32'h12345678, 0);
    n = 0;
    while (!transmit && n < 20) begin
      @(posedge masterClock); #1;
      n++;
    end
    check("send reached", transmit, 1'b1);
    applyReset("send reset");

    // Normal operation after reset
    sendPacket(8'h21, 32'hCAFEF00D, 0, 0, -1, 32'h0);
    check("post reset status", respStatus, 8'h09);
    check("post reset regs", regFile, {32'h0, 32'h0, 32'hCAFEF00D, 32'h0});
    sendPacket(8'h43, 32'h0, 0, 0, -1, 32'h0);
    check("post reset read", respData, 32'h0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
